// File: rtl/mario_pkg.sv
// Shared definitions for the Mario-world sprite blocks: coordinate widths,
// default sprite sizes and the contact detector's FSM encoding.
package mario_pkg;

  localparam int COORD_W = 11;
  localparam int EDGE_W  = COORD_W + 1;

  localparam int MARIO_W_DEF         = 16;
  localparam int MARIO_H_DEF         = 16;
  localparam int GOOMBA_W_DEF        = 16;
  localparam int GOOMBA_H_DEF        = 16;
  localparam int STOMP_MARGIN_DEF    = 4;
  localparam int COOLDOWN_FRAMES_DEF = 30;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [EDGE_W-1:0]  edge_t;

  typedef enum logic [1:0] {
    ARMED    = 2'd0,
    COOLDOWN = 2'd1,
    DISABLED = 2'd2
  } det_state_e;

  typedef struct packed {
    coord_t mario_x;
    coord_t mario_y;
    logic   mario_falling;
    coord_t goomba_x;
    coord_t goomba_y;
    logic   goomba_live;
  } frame_sample_t;

  // Far edge of a box, one bit wider than a coordinate so it never wraps.
  function automatic edge_t far_edge(input coord_t pos, input int unsigned size);
    return edge_t'(pos) + edge_t'(size);
  endfunction

endpackage

// File: rtl/goomba_contact_detector_if.sv
// Per-frame position inputs and impulse outputs of the Goomba contact detector.
interface goomba_contact_detector_if;
  import mario_pkg::*;

  logic   frame_tick;
  coord_t mario_x;
  coord_t mario_y;
  logic   mario_falling;
  coord_t goomba_w;
  coord_t goomba_h;
  logic   goomba_live;
  logic   press_impulse;
  logic   collapsion_impulse;
  logic   contact;
  logic   cooling;

  modport master (
    output frame_tick, mario_x, mario_y, mario_falling, goomba_w, goomba_h, goomba_live,
    input  press_impulse, collapsion_impulse, contact, cooling
  );

  modport slave (
    input  frame_tick, mario_x, mario_y, mario_falling, goomba_w, goomba_h, goomba_live,
    output press_impulse, collapsion_impulse, contact, cooling
  );

endinterface

// File: rtl/goomba_contact_detector_box_overlap.sv
// Combinational box-vs-box test: strict overlap (touching edges do not count)
// plus a stomp flag when a falling box A lands within MARGIN of B's top edge.
module box_overlap
  import mario_pkg::*;
#(
  parameter int A_W    = MARIO_W_DEF,
  parameter int A_H    = MARIO_H_DEF,
  parameter int B_W    = GOOMBA_W_DEF,
  parameter int B_H    = GOOMBA_H_DEF,
  parameter int MARGIN = STOMP_MARGIN_DEF
) (
  input  coord_t a_x,
  input  coord_t a_y,
  input  coord_t b_x,
  input  coord_t b_y,
  input  logic   a_falling,
  output logic   overlap,
  output logic   stomp
);

  edge_t a_right;
  edge_t a_bottom;
  edge_t b_right;
  edge_t b_bottom;
  edge_t b_stomp_line;

  assign a_right      = far_edge(a_x, A_W);
  assign a_bottom     = far_edge(a_y, A_H);
  assign b_right      = far_edge(b_x, B_W);
  assign b_bottom     = far_edge(b_y, B_H);
  assign b_stomp_line = far_edge(b_y, MARGIN);

  assign overlap = (edge_t'(a_x) < b_right)  && (edge_t'(b_x) < a_right) &&
                   (edge_t'(a_y) < b_bottom) && (edge_t'(b_y) < a_bottom);

  assign stomp = overlap && a_falling && (a_bottom <= b_stomp_line);

endmodule

// File: rtl/goomba_contact_detector.sv
// Per-frame Mario/Goomba contact classifier: sample, compare, then an
// arm/cooldown FSM that turns one contact into a single stomp or side impulse.
module goomba_contact_detector
  import mario_pkg::*;
#(
  parameter int MARIO_W         = MARIO_W_DEF,
  parameter int MARIO_H         = MARIO_H_DEF,
  parameter int GOOMBA_W        = GOOMBA_W_DEF,
  parameter int GOOMBA_H        = GOOMBA_H_DEF,
  parameter int STOMP_MARGIN    = STOMP_MARGIN_DEF,
  parameter int COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEF
) (
  input logic clk,
  input logic rstn,
  goomba_contact_detector_if.slave bus
);

  localparam int CNT_W = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  frame_sample_t s1;
  logic          s1_valid;
  logic          cmp_overlap;
  logic          cmp_stomp;

  logic s2_valid;
  logic s2_overlap;
  logic s2_stomp;
  logic s2_live;

  det_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             press_q, press_nxt;
  logic             coll_q, coll_nxt;
  logic             contact_q;

  // NOTE: non-blocking assignments let every stage see the previous cycle's values.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else begin
      s1_valid <= bus.frame_tick;
      if (bus.frame_tick) begin
        s1 <= '{mario_x:       bus.mario_x,
                mario_y:       bus.mario_y,
                mario_falling: bus.mario_falling,
                goomba_x:      bus.goomba_w,
                goomba_y:      bus.goomba_h,
                goomba_live:   bus.goomba_live};
      end
    end
  end

  box_overlap #(
    .A_W    (MARIO_W),
    .A_H    (MARIO_H),
    .B_W    (GOOMBA_W),
    .B_H    (GOOMBA_H),
    .MARGIN (STOMP_MARGIN)
  ) u_box (
    .a_x       (s1.mario_x),
    .a_y       (s1.mario_y),
    .b_x       (s1.goomba_x),
    .b_y       (s1.goomba_y),
    .a_falling (s1.mario_falling),
    .overlap   (cmp_overlap),
    .stomp     (cmp_stomp)
  );

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      s2_valid   <= 1'b0;
      s2_overlap <= 1'b0;
      s2_stomp   <= 1'b0;
      s2_live    <= 1'b0;
    end else begin
      s2_valid   <= s1_valid;
      s2_overlap <= cmp_overlap;
      s2_stomp   <= cmp_stomp;
      s2_live    <= s1.goomba_live;
    end
  end

  // Cooldown counts frames as they leave the pipeline, so the frames that
  // were already in flight when the impulse fired are the ones it swallows.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    press_nxt = 1'b0;
    coll_nxt  = 1'b0;
    if (s2_valid && !s2_live) begin
      state_nxt = DISABLED;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ARMED: begin
          if (s2_valid && s2_overlap) begin
            press_nxt = s2_stomp;
            coll_nxt  = !s2_stomp;
            state_nxt = COOLDOWN;
            cnt_nxt   = CNT_LOAD;
          end
        end
        COOLDOWN: begin
          if (cnt == '0) begin
            state_nxt = ARMED;
          end else if (s2_valid) begin
            cnt_nxt = cnt - CNT_ONE;
            if (cnt == CNT_ONE) state_nxt = ARMED;
          end
        end
        DISABLED: begin
          if (s2_valid) begin
            state_nxt = ARMED;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = ARMED;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state     <= ARMED;
      cnt       <= '0;
      press_q   <= 1'b0;
      coll_q    <= 1'b0;
      contact_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      press_q <= press_nxt;
      coll_q  <= coll_nxt;
      if (s2_valid) contact_q <= s2_overlap;
    end
  end

  assign bus.press_impulse      = press_q;
  assign bus.collapsion_impulse = coll_q;
  assign bus.contact            = contact_q;
  assign bus.cooling            = (state == COOLDOWN);

endmodule

// File: tb/tb_goomba_contact_detector.sv
// Directed bench: one detector with a 3-frame cooldown and one with none,
// both fed the same frames; impulses are checked two edges after each tick.
module tb_goomba_contact_detector;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  goomba_contact_detector_if bus3 ();
  goomba_contact_detector_if bus0 ();

  assign bus0.frame_tick    = bus3.frame_tick;
  assign bus0.mario_x       = bus3.mario_x;
  assign bus0.mario_y       = bus3.mario_y;
  assign bus0.mario_falling = bus3.mario_falling;
  assign bus0.goomba_w      = bus3.goomba_w;
  assign bus0.goomba_h      = bus3.goomba_h;
  assign bus0.goomba_live   = bus3.goomba_live;

  goomba_contact_detector #(.COOLDOWN_FRAMES(3)) dut3 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus3)
  );

  goomba_contact_detector #(.COOLDOWN_FRAMES(0)) dut0 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_pos(input int mx, input int my, input int gx, input int gy,
                         input logic fall, input logic live);
    bus3.mario_x       = 11'(mx);
    bus3.mario_y       = 11'(my);
    bus3.goomba_w      = 11'(gx);
    bus3.goomba_h      = 11'(gy);
    bus3.mario_falling = fall;
    bus3.goomba_live   = live;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ":press3"},   32'(bus3.press_impulse),      0);
    check({tag, ":coll3"},    32'(bus3.collapsion_impulse), 0);
    check({tag, ":contact3"}, 32'(bus3.contact),            0);
    check({tag, ":cool3"},    32'(bus3.cooling),            0);
    check({tag, ":press0"},   32'(bus0.press_impulse),      0);
    check({tag, ":coll0"},    32'(bus0.collapsion_impulse), 0);
    check({tag, ":cool0"},    32'(bus0.cooling),            0);
  endtask

  // One isolated frame: tick sampled at edge N, impulse expected after N+2 only.
  task automatic run_frame(input string tag, input int mx, input int my, input int gx,
                           input int gy, input logic fall, input logic live,
                           input logic e_press, input logic e_coll, input logic e_contact,
                           input logic e_cool, input logic e0_press, input logic e0_coll);
    @(negedge clk);
    set_pos(mx, my, gx, gy, fall, live);
    bus3.frame_tick = 1'b1;
    @(negedge clk);
    bus3.frame_tick = 1'b0;
    @(posedge clk); #1;
    check({tag, ":early_press"}, 32'(bus3.press_impulse | bus0.press_impulse), 0);
    check({tag, ":early_coll"},  32'(bus3.collapsion_impulse | bus0.collapsion_impulse), 0);
    @(posedge clk); #1;
    check({tag, ":press3"},   32'(bus3.press_impulse),      32'(e_press));
    check({tag, ":coll3"},    32'(bus3.collapsion_impulse), 32'(e_coll));
    check({tag, ":contact3"}, 32'(bus3.contact),            32'(e_contact));
    check({tag, ":cool3"},    32'(bus3.cooling),            32'(e_cool));
    check({tag, ":press0"},   32'(bus0.press_impulse),      32'(e0_press));
    check({tag, ":coll0"},    32'(bus0.collapsion_impulse), 32'(e0_coll));
    check({tag, ":cool0"},    32'(bus0.cooling),            32'(e0_press | e0_coll));
    @(posedge clk); #1;
    check({tag, ":late_press"}, 32'(bus3.press_impulse | bus0.press_impulse), 0);
    check({tag, ":late_coll"},  32'(bus3.collapsion_impulse | bus0.collapsion_impulse), 0);
    check({tag, ":late_cool0"}, 32'(bus0.cooling), 0);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstn = 1'b1;
    bus3.frame_tick = 1'b0;
    set_pos(100, 200, 100, 214, 1'b1, 1'b1);

    // A tick while reset is held must leave no trace.
    repeat (2) @(negedge clk);
    bus3.frame_tick = 1'b1;
    @(negedge clk); #1;
    check_quiet("in_reset");
    bus3.frame_tick = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk); #1;
    check_quiet("post_release");
    repeat (3) @(posedge clk);
    #1 check_quiet("reset_tick_ignored");

    //        tag           mx    my   gx    gy fall live  prs col con cool  p0 c0
    run_frame("touch",      84,  214, 100,  214, 0, 1,     0,  0,  0,  0,    0, 0);
    run_frame("side",       90,  214, 100,  214, 0, 1,     0,  1,  1,  1,    0, 1);
    run_frame("cd_stomp",  100,  200, 100,  214, 1, 1,     0,  0,  1,  1,    1, 0);
    run_frame("cd_far1",     0,    0, 500,  500, 0, 1,     0,  0,  0,  1,    0, 0);
    run_frame("cd_far2",     0,    0, 500,  500, 0, 1,     0,  0,  0,  0,    0, 0);
    run_frame("stomp_t1",  100,  200, 100,  214, 1, 1,     1,  0,  1,  1,    1, 0);
    run_frame("stomp_t2",  100,  200, 100,  214, 1, 1,     0,  0,  1,  1,    1, 0);
    run_frame("stomp_t3",  100,  200, 100,  214, 1, 1,     0,  0,  1,  1,    1, 0);
    run_frame("stomp_t4",  100,  200, 100,  214, 1, 1,     0,  0,  1,  0,    1, 0);
    run_frame("stomp_t5",  100,  200, 100,  214, 1, 1,     1,  0,  1,  1,    1, 0);
    run_frame("far_a1",      0,    0, 500,  500, 0, 1,     0,  0,  0,  1,    0, 0);
    run_frame("far_a2",      0,    0, 500,  500, 0, 1,     0,  0,  0,  1,    0, 0);
    run_frame("far_a3",      0,    0, 500,  500, 0, 1,     0,  0,  0,  0,    0, 0);
    run_frame("wide_x",   2030,  214, 2040, 214, 0, 1,     0,  1,  1,  1,    0, 1);
    run_frame("far_b1",      0,    0, 500,  500, 0, 1,     0,  0,  0,  1,    0, 0);
    run_frame("far_b2",      0,    0, 500,  500, 0, 1,     0,  0,  0,  1,    0, 0);
    run_frame("far_b3",      0,    0, 500,  500, 0, 1,     0,  0,  0,  0,    0, 0);
    run_frame("too_deep",  100,  205, 100,  214, 1, 1,     0,  1,  1,  1,    0, 1);
    run_frame("far_c1",      0,    0, 500,  500, 0, 1,     0,  0,  0,  1,    0, 0);
    run_frame("far_c2",      0,    0, 500,  500, 0, 1,     0,  0,  0,  1,    0, 0);
    run_frame("far_c3",      0,    0, 500,  500, 0, 1,     0,  0,  0,  0,    0, 0);
    run_frame("margin_edge",100, 202, 100,  214, 1, 1,     1,  0,  1,  1,    1, 0);
    run_frame("dead_stomp",100,  200, 100,  214, 1, 0,     0,  0,  1,  0,    0, 0);

    // Back-to-back ticks while disabled: contact must follow each sample.
    @(negedge clk);
    set_pos(100, 200, 100, 214, 1'b1, 1'b0);
    bus3.frame_tick = 1'b1;
    @(negedge clk);
    set_pos(0, 0, 500, 500, 1'b0, 1'b0);
    @(negedge clk);
    bus3.frame_tick = 1'b0;
    @(posedge clk); #1;
    check("b2b_a:contact3", 32'(bus3.contact), 1);
    check("b2b_a:press3",   32'(bus3.press_impulse | bus0.press_impulse), 0);
    @(posedge clk); #1;
    check("b2b_b:contact3", 32'(bus3.contact), 0);
    check("b2b_b:coll3",    32'(bus3.collapsion_impulse | bus0.collapsion_impulse), 0);
    repeat (3) @(posedge clk);

    run_frame("revive",      0,    0, 500,  500, 0, 1,     0,  0,  0,  0,    0, 0);
    run_frame("live_stomp",100,  200, 100,  214, 1, 1,     1,  0,  1,  1,    1, 0);

    // Short reset pulse mid-cooldown with a stomp frame still in the pipeline.
    @(negedge clk);
    set_pos(100, 200, 100, 214, 1'b1, 1'b1);
    bus3.frame_tick = 1'b1;
    @(negedge clk);
    bus3.frame_tick = 1'b0;
    #2 rstn = 1'b1;
    #1 check_quiet("mid_reset");
    #3 rstn = 1'b0;
    @(posedge clk); #1;
    check_quiet("inflight_dropped");
    @(posedge clk); #1;
    check_quiet("inflight_dropped2");
    repeat (3) @(posedge clk);

    run_frame("after_rst", 100,  200, 100,  214, 1, 1,     1,  0,  1,  1,    1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
